mask_builder: RTL and testbench
===============================

MASK_BUILDER -- requirements
Module: mask_builder

Interface
REQ-001 SHALL have parameter NENTRIES, default 8, giving the mask width in entries (legal range 2..256).
REQ-002 SHALL derive local parameter IDXW = $clog2(NENTRIES), the index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  index beat offered.
REQ-006 SHALL have port in_ready  output  1  index beat accepted when in_valid && in_ready.
REQ-007 SHALL have port in_idx  input  IDXW  entry index to set.
REQ-008 SHALL have port in_last  input  1  final beat of the current set.
REQ-009 SHALL have port out_valid  output  1  completed mask offered.
REQ-010 SHALL have port out_ready  input  1  mask consumed when out_valid && out_ready.
REQ-011 SHALL have port out_mask  output  NENTRIES  accumulated set bits, bit i = entry i.
REQ-012 SHALL have port out_count  output  IDXW+1  number of distinct bits set in out_mask.
REQ-013 SHALL have port out_dup  output  1  at least one accepted index was already set.
REQ-014 SHALL have port out_oob  output  1  at least one accepted index was >= NENTRIES.

Function
REQ-015 SHALL implement a two-state FSM: ACCUM (collecting beats) and HOLD (presenting result).
REQ-016 SHALL drive in_ready = 1 exactly when in ACCUM, and out_valid = 1 exactly when in HOLD; both are registered-state decodes with no combinational path from in_valid or out_ready.
REQ-017 On an accepted beat with in_idx < NENTRIES and mask bit clear: SHALL set that bit and increment count by 1.
REQ-018 On an accepted beat with in_idx < NENTRIES and mask bit already set: SHALL leave mask and count unchanged and set the sticky dup flag.
REQ-019 On an accepted beat with in_idx >= NENTRIES (only possible for non-power-of-2 NENTRIES): SHALL leave mask and count unchanged and set the sticky oob flag.
REQ-020 On an accepted beat with in_last = 1: SHALL apply REQ-017..019 for that beat and transition ACCUM -> HOLD; out_valid rises the cycle after acceptance, showing the mask including the last beat.
REQ-021 SHALL hold out_mask, out_count, out_dup and out_oob stable throughout HOLD until the output handshake completes.
REQ-022 On the output handshake: SHALL transition HOLD -> ACCUM and clear mask, count, dup and oob to 0 in the same edge; in_ready returns to 1 the following cycle.
REQ-023 In HOLD, in_valid SHALL be ignored; no beat is accepted and no state changes other than via REQ-022.
REQ-024 out_count SHALL never exceed NENTRIES; IDXW+1 bits SHALL hold NENTRIES without wrap.
REQ-025 In ACCUM, outputs out_mask/out_count/out_dup/out_oob SHALL reflect the partial accumulation but carry no meaning while out_valid = 0.
REQ-026 A set with a single beat (in_last on first beat) SHALL be legal; minimum set-to-result latency is 1 cycle, minimum throughput one set per 2 cycles.

Reset
REQ-027 While rst = 1: FSM = ACCUM, in_ready = 1, out_valid = 0, out_mask = 0, out_count = 0, out_dup = 0, out_oob = 0, effective immediately without a clock edge.
REQ-028 Reset asserted mid-set or during HOLD SHALL discard all partial or pending results; no mask is presented after release until a new in_last beat is accepted.

Verification
REQ-029 NENTRIES=8: beats 3, 0, 7(last), out_ready=1 -> one cycle after last, out_valid=1, out_mask=8'b1000_1001, out_count=4'd3, dup=0, oob=0; next cycle in_ready=1, mask=0.
REQ-030 NENTRIES=8: beats 5, 5(last) -> out_mask=8'b0010_0000, out_count=1, out_dup=1.
REQ-031 NENTRIES=6: beats 2, 7(last) -> out_mask=6'b00_0100, out_count=1, out_oob=1, out_dup=0.
REQ-032 NENTRIES=8: beat 1(last) with out_ready=0 for 5 cycles while in_valid=1 idx=4 -> out_valid held, out_mask=8'b0000_0010 unchanged, in_ready=0, idx 4 not absorbed; after out_ready pulse, next set starts from 0.
REQ-033 NENTRIES=8: beats 0..7 with 7 last -> out_mask=8'hFF, out_count=4'd8 (no wrap).
REQ-034 Assert rst asynchronously after beats 1, 2 (no last) -> outputs zero immediately; after release, beat 6(last) -> out_mask=8'b0100_0000, out_count=1.

Source files
------------

// File: rtl/mask_builder.sv
// Accumulates a set of entry indices into a bit mask, then holds the completed
// mask (with distinct-bit count and duplicate/out-of-range flags) until consumed.
module mask_builder #(
    parameter  int NENTRIES = 8,
    localparam int IDXW     = $clog2(NENTRIES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IDXW-1:0]     in_idx,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NENTRIES-1:0] out_mask,
    output logic [IDXW:0]       out_count,
    output logic                out_dup,
    output logic                out_oob
);

    localparam int                CW  = IDXW + 1;
    localparam logic [NENTRIES-1:0] ONE = NENTRIES'(1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [NENTRIES-1:0] mask;
    logic [CW-1:0]       count;
    logic                dup;
    logic                oob;

    logic                accept;
    logic                handshake;
    logic                in_range;
    logic [NENTRIES-1:0] hit;
    logic                already;

    // NOTE: every register here is cleared by the asynchronous reset so that
    // the outputs read zero as soon as rst rises, without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: combinational blocks assign a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (in_valid && in_last) state_next = HOLD;
            HOLD:    if (out_ready)           state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // Handshake outputs decode the registered state only.
    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == HOLD);
    end

    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    // Shifting past the top of the mask yields zero, so an out-of-range index
    // never touches a mask bit and never reads one as already set.
    assign hit     = ONE << in_idx;
    assign already = |(mask & hit);

    generate
        if (NENTRIES == (1 << IDXW)) begin : g_pow2
            assign in_range = 1'b1;
        end else begin : g_npow2
            localparam logic [IDXW:0] LIMIT = CW'(NENTRIES);
            assign in_range = {1'b0, in_idx} < LIMIT;
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask  <= '0;
            count <= '0;
            dup   <= 1'b0;
            oob   <= 1'b0;
        end else if (handshake) begin
            mask  <= '0;
            count <= '0;
            dup   <= 1'b0;
            oob   <= 1'b0;
        end else if (accept) begin
            if (!in_range) begin
                oob <= 1'b1;
            end else if (already) begin
                dup <= 1'b1;
            end else begin
                mask  <= mask | hit;
                count <= count + CW'(1);
            end
        end
    end

    assign out_mask  = mask;
    assign out_count = count;
    assign out_dup   = dup;
    assign out_oob   = oob;

endmodule

// File: tb/tb_mask_builder.sv
// Drives identical beats into an 8-entry and a 6-entry mask_builder and checks
// both against a set-based model, plus hand-computed scenario expectations.
`timescale 1ns/1ps
module tb_mask_builder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_idx = '0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready8, out_valid8, dup8, oob8;
    logic [7:0] mask8;
    logic [3:0] count8;
    logic       in_ready6, out_valid6, dup6, oob6;
    logic [5:0] mask6;
    logic [3:0] count6;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Model: which indices have been seen in the current set, per instance.
    int ne [2] = '{8, 6};
    bit seen [2][8];
    bit mdup [2];
    bit moob [2];
    bit mhold;

    always #5 clk = ~clk;

    mask_builder #(.NENTRIES(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready8), .in_idx(in_idx), .in_last(in_last),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_mask(mask8), .out_count(count8), .out_dup(dup8), .out_oob(oob8)
    );

    mask_builder #(.NENTRIES(6)) dut6 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready6), .in_idx(in_idx), .in_last(in_last),
        .out_valid(out_valid6), .out_ready(out_ready),
        .out_mask(mask6), .out_count(count6), .out_dup(dup6), .out_oob(oob6)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] exp_mask(input int k);
        logic [7:0] m = '0;
        for (int i = 0; i < 8; i++) if (seen[k][i]) m[i] = 1'b1;
        return m;
    endfunction

    function automatic int exp_count(input int k);
        int c = 0;
        for (int i = 0; i < 8; i++) if (seen[k][i]) c++;
        return c;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) seen[k][i] = 1'b0;
            mdup[k] = 1'b0;
            moob[k] = 1'b0;
        end
        mhold = 1'b0;
    endtask

    // Applies the inputs that were stable across the edge just taken.
    task automatic model_step();
        int idx;
        if (!mhold) begin
            if (in_valid) begin
                idx = int'(in_idx);
                for (int k = 0; k < 2; k++) begin
                    if (idx >= ne[k])     moob[k] = 1'b1;
                    else if (seen[k][idx]) mdup[k] = 1'b1;
                    else                   seen[k][idx] = 1'b1;
                end
                if (in_last) mhold = 1'b1;
            end
        end else if (out_ready) begin
            model_clear();
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic beat(input int idx, input bit last);
        in_valid = 1'b1;
        in_idx   = 3'(idx);
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_clear();
        check("rst_in_ready8", in_ready8, 1);
        check("rst_out_valid8", out_valid8, 0);
        check("rst_mask8", mask8, 0);
        check("rst_count8", count8, 0);
        check("rst_flags8", {dup8, oob8}, 0);
        check("rst_out_valid6", out_valid6, 0);
        check("rst_mask6", mask6, 0);
        #1;
        rst = 1'b0;
    endtask

    task automatic compare_dut(input int k, input logic ir, input logic ov, input logic [7:0] m,
                               input logic [3:0] c, input logic d, input logic o);
        check($sformatf("k%0d_in_ready", ne[k]), ir, !mhold);
        check($sformatf("k%0d_out_valid", ne[k]), ov, mhold);
        if (mhold) begin
            check($sformatf("k%0d_mask", ne[k]), m, exp_mask(k));
            check($sformatf("k%0d_count", ne[k]), c, exp_count(k));
            check($sformatf("k%0d_dup", ne[k]), d, mdup[k]);
            check($sformatf("k%0d_oob", ne[k]), o, moob[k]);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            compare_dut(0, in_ready8, out_valid8, mask8, count8, dup8, oob8);
            compare_dut(1, in_ready6, out_valid6, {2'b00, mask6}, count6, dup6, oob6);
        end
    end

    initial begin
        model_clear();
        #2;
        check("por_mask8", mask8, 0);
        check("por_in_ready8", in_ready8, 1);
        check("por_out_valid8", out_valid8, 0);
        #10;
        rst = 1'b0;
        cmp_en = 1'b1;
        step();

        // Three distinct beats; the 6-entry instance sees index 7 as out of range.
        out_ready = 1'b1;
        beat(3, 0);
        beat(0, 0);
        beat(7, 1);
        check("s1_out_valid8", out_valid8, 1);
        check("s1_mask8", mask8, 8'b1000_1001);
        check("s1_count8", count8, 3);
        check("s1_flags8", {dup8, oob8}, 2'b00);
        check("s1_mask6", mask6, 6'b00_1001);
        check("s1_count6", count6, 2);
        check("s1_oob6", oob6, 1);
        step();
        check("s1_in_ready_after", in_ready8, 1);
        check("s1_mask_cleared", mask8, 0);

        // Duplicate index.
        beat(5, 0);
        beat(5, 1);
        check("s2_mask8", mask8, 8'b0010_0000);
        check("s2_count8", count8, 1);
        check("s2_dup8", dup8, 1);
        step();

        // Out-of-range only on the 6-entry instance.
        beat(2, 0);
        beat(7, 1);
        check("s3_mask6", mask6, 6'b00_0100);
        check("s3_count6", count6, 1);
        check("s3_flags6", {dup6, oob6}, 2'b01);
        step();

        // Backpressure: result held, new beats ignored.
        out_ready = 1'b0;
        beat(1, 1);
        in_valid = 1'b1;
        in_idx   = 3'd4;
        for (int i = 0; i < 5; i++) begin
            step();
            check("s4_out_valid_held", out_valid8, 1);
            check("s4_mask_held", mask8, 8'b0000_0010);
            check("s4_in_ready_low", in_ready8, 0);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("s4_mask_cleared", mask8, 0);
        beat(4, 1);
        check("s4_next_mask", mask8, 8'b0001_0000);
        check("s4_next_count", count8, 1);
        step();

        // Full mask: count must reach 8 without wrapping.
        for (int i = 0; i < 8; i++) beat(i, i == 7);
        check("s5_mask8", mask8, 8'hFF);
        check("s5_count8", count8, 8);
        check("s5_mask6", mask6, 6'h3F);
        check("s5_count6", count6, 6);
        check("s5_oob6", oob6, 1);
        step();

        // Reset mid-set discards the partial accumulation.
        beat(1, 0);
        beat(2, 0);
        async_reset();
        beat(6, 1);
        check("s6_out_valid8", out_valid8, 1);
        check("s6_mask8", mask8, 8'b0100_0000);
        check("s6_count8", count8, 1);
        check("s6_count6", count6, 0);
        check("s6_oob6", oob6, 1);
        step();

        // Randomized traffic against the model, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_idx    = 3'($urandom_range(0, 7));
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 99) == 0) async_reset();
            step();
        end

        in_valid = 1'b0;
        step();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
